// File: rtl/param_cpu_core_if.sv
// Core-side bundle for param_cpu_core: ROM fetch bus, I/O ports, control strobes and status.
// The master modport is the core and the slave modport is the surrounding board logic.
interface param_cpu_core_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
);
   localparam int INST_W = 4 + DATA_W;

   logic              tick;
   logic              step_mode;
   logic              step;
   logic [ADDR_W-1:0] inst_adrs;
   logic [INST_W-1:0] inst;
   logic [DATA_W-1:0] io_in;
   logic [DATA_W-1:0] io_out;
   logic              flag_c;
   logic              flag_z;
   logic              retire;
   logic              halted;

   modport master (
      input  tick, step_mode, step, inst, io_in,
      output inst_adrs, io_out, flag_c, flag_z, retire, halted
   );

   modport slave (
      output tick, step_mode, step, inst, io_in,
      input  inst_adrs, io_out, flag_c, flag_z, retire, halted
   );
endinterface

// File: rtl/param_cpu_core.sv
// Parametrised TD4-style core: A/B registers, C/Z flags and an OUT port.
// Fetch waits ROM_LAT cycles after every PC change, then executes on tick or on a step edge.
//
// state    | meaning
// ST_WAIT  | ROM output settling after a PC change; lat_q counts down
// ST_READY | inst valid; execute on adv
// ST_HALT  | HALT executed; frozen until reset
module param_cpu_core #(
   parameter int DATA_W  = 4,
   parameter int ADDR_W  = 4,
   parameter int ROM_LAT = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   param_cpu_core_if.master bus
);
   localparam int INST_W = 4 + DATA_W;

   localparam logic [1:0] ST_WAIT  = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [1:0] LAT_INIT = 2'(ROM_LAT);
   localparam logic [1:0] ST_FETCH = (ROM_LAT == 0) ? ST_READY : ST_WAIT;

   generate
      if (ADDR_W > DATA_W) begin : g_bad_addr_w
         $error("param_cpu_core: ADDR_W must not exceed DATA_W");
      end
      if (ROM_LAT < 0 || ROM_LAT > 3) begin : g_bad_rom_lat
         $error("param_cpu_core: ROM_LAT must be in 0..3");
      end
   endgenerate

   logic [1:0]        state_q, state_d;
   logic [1:0]        lat_q, lat_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic              retire_q, retire_d;
   logic              pending_q, pending_d;
   logic              step_q;

   logic [3:0]        op;
   logic [DATA_W-1:0] imm;
   logic [ADDR_W-1:0] target;
   logic [DATA_W:0]   sum_a, sum_b, diff_a;
   logic              step_rise;
   logic              adv;

   assign op        = bus.inst[INST_W-1 -: 4];
   assign imm       = bus.inst[DATA_W-1:0];
   assign target    = imm[ADDR_W-1:0];
   assign sum_a     = {1'b0, a_q} + {1'b0, imm};
   assign sum_b     = {1'b0, b_q} + {1'b0, imm};
   assign diff_a    = {1'b0, a_q} - {1'b0, imm};
   assign step_rise = bus.step & ~step_q;
   assign adv       = bus.step_mode ? (step_rise | pending_q) : bus.tick;

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      pc_d      = pc_q;
      a_d       = a_q;
      b_d       = b_q;
      out_d     = out_q;
      c_d       = c_q;
      z_d       = z_q;
      retire_d  = 1'b0;
      pending_d = pending_q;
      case (state_q)
         ST_WAIT: begin
            if (step_rise) pending_d = 1'b1;
            if (lat_q <= 2'd1) state_d = ST_READY;
            else               lat_d   = lat_q - 2'd1;
         end
         ST_READY: begin
            pending_d = 1'b0;
            if (adv) begin
               retire_d = 1'b1;
               state_d  = ST_FETCH;
               lat_d    = LAT_INIT;
               pc_d     = pc_q + ADDR_W'(1);
               c_d      = 1'b0;
               case (op)
                  4'h0: begin {c_d, a_d} = sum_a; z_d = (sum_a[DATA_W-1:0] == '0); end
                  4'h1, 4'hD: a_d = b_q;
                  4'h2: a_d = bus.io_in;
                  4'h3: a_d = imm;
                  4'h4: b_d = a_q;
                  4'h5: begin {c_d, b_d} = sum_b; z_d = (sum_b[DATA_W-1:0] == '0); end
                  4'h6: b_d = bus.io_in;
                  4'h7: b_d = imm;
                  // borrow out of the extended subtraction is exactly imm > A
                  4'h8: begin {c_d, a_d} = diff_a; z_d = (diff_a[DATA_W-1:0] == '0); end
                  4'h9: out_d = b_q;
                  4'hA: if (z_q) pc_d = target;
                  4'hB: out_d = imm;
                  4'hC: begin state_d = ST_HALT; pc_d = pc_q; end
                  4'hE: if (!c_q) pc_d = target;
                  4'hF: pc_d = target;
               endcase
            end
         end
         ST_HALT: pending_d = 1'b0;
         default: begin
            state_d = ST_WAIT;
            lat_d   = LAT_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_FETCH;
         lat_q     <= LAT_INIT;
         pc_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         out_q     <= '0;
         c_q       <= 1'b0;
         z_q       <= 1'b0;
         retire_q  <= 1'b0;
         pending_q <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         pc_q      <= pc_d;
         a_q       <= a_d;
         b_q       <= b_d;
         out_q     <= out_d;
         c_q       <= c_d;
         z_q       <= z_d;
         retire_q  <= retire_d;
         pending_q <= pending_d;
         step_q    <= bus.step;
      end
   end

   assign bus.inst_adrs = pc_q;
   assign bus.io_out    = out_q;
   assign bus.flag_c    = c_q;
   assign bus.flag_z    = z_q;
   assign bus.retire    = retire_q;
   assign bus.halted    = (state_q == ST_HALT);
endmodule

// File: tb/tb_param_cpu_core.sv
// Bench for param_cpu_core: two instances (ROM_LAT=1 registered ROM, ROM_LAT=0 combinational ROM)
// checked against an instruction-level interpreter on every retire pulse.
module tb_param_cpu_core;
   localparam int DW = 4;
   localparam int AW = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       step_mode = 1'b0;
   logic       step = 1'b0;
   logic [3:0] io_in = 4'h0;
   logic [7:0] rom1 [16];
   logic [7:0] rom0 [16];
   logic [7:0] inst1_q;

   param_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
   param_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

   assign bus1.tick = tick;  assign bus1.step_mode = step_mode;
   assign bus1.step = step;  assign bus1.io_in = io_in;
   assign bus0.tick = tick;  assign bus0.step_mode = step_mode;
   assign bus0.step = step;  assign bus0.io_in = io_in;

   always @(posedge clk) inst1_q <= rom1[bus1.inst_adrs];
   assign bus1.inst = inst1_q;
   assign bus0.inst = rom0[bus0.inst_adrs];

   param_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .ROM_LAT(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1));
   param_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .ROM_LAT(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit use0 = 1'b0;
   int m_a, m_b, m_c, m_z, m_pc, m_out, m_halt;
   int retires;
   logic [3:0] o_pc, o_out;
   logic       o_c, o_z, o_ret, o_halt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      if (use0) begin
         o_pc = bus0.inst_adrs; o_out = bus0.io_out; o_c = bus0.flag_c;
         o_z = bus0.flag_z; o_ret = bus0.retire; o_halt = bus0.halted;
      end else begin
         o_pc = bus1.inst_adrs; o_out = bus1.io_out; o_c = bus1.flag_c;
         o_z = bus1.flag_z; o_ret = bus1.retire; o_halt = bus1.halted;
      end
   endtask

   // Instruction-set interpreter: one call per executed instruction.
   task automatic model_exec(input int io);
      int ins, op, imm, s, npc, nc;
      ins = use0 ? int'(rom0[m_pc]) : int'(rom1[m_pc]);
      op = ins / 16; imm = ins % 16;
      npc = (m_pc + 1) % 16; nc = 0;
      case (op)
         0:  begin s = m_a + imm; nc = (s > 15) ? 1 : 0; m_a = s % 16; m_z = (m_a == 0) ? 1 : 0; end
         1, 13: m_a = m_b;
         2:  m_a = io;
         3:  m_a = imm;
         4:  m_b = m_a;
         5:  begin s = m_b + imm; nc = (s > 15) ? 1 : 0; m_b = s % 16; m_z = (m_b == 0) ? 1 : 0; end
         6:  m_b = io;
         7:  m_b = imm;
         8:  begin nc = (imm > m_a) ? 1 : 0; m_a = (m_a - imm + 16) % 16; m_z = (m_a == 0) ? 1 : 0; end
         9:  m_out = m_b;
         10: if (m_z == 1) npc = imm;
         11: m_out = imm;
         12: begin m_halt = 1; npc = m_pc; end
         14: if (m_c == 0) npc = imm;
         15: npc = imm;
         default: ;
      endcase
      m_c = nc; m_pc = npc;
   endtask

   task automatic cycle();
      @(negedge clk);
      sample();
      if (o_ret === 1'b1) begin
         if (m_halt == 1) check("retire_after_halt", 32'(o_ret), 0);
         else begin
            model_exec(int'(io_in));
            retires++;
            check("pc", 32'(o_pc), m_pc);
            check("io_out", 32'(o_out), m_out);
            check("flag_c", 32'(o_c), m_c);
            check("flag_z", 32'(o_z), m_z);
         end
      end
      check("halted", 32'(o_halt), m_halt);
      io_in = 4'($urandom);
   endtask

   task automatic do_reset();
      tick = 1'b0; step = 1'b0; step_mode = 1'b0;
      reset_n = 1'b0;
      m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_pc = 0; m_out = 0; m_halt = 0; retires = 0;
      @(negedge clk); @(negedge clk);
      sample();
      check("rst_pc", 32'(o_pc), 0);     check("rst_out", 32'(o_out), 0);
      check("rst_c", 32'(o_c), 0);       check("rst_z", 32'(o_z), 0);
      check("rst_retire", 32'(o_ret), 0); check("rst_halted", 32'(o_halt), 0);
      reset_n = 1'b1;
   endtask

   task automatic wait_retires(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && retires < n; i++) cycle();
      check(tag, retires, n);
   endtask

   task automatic fill_safe(input int upto);
      logic [3:0] op;
      for (int i = 0; i < upto; i++) begin
         do op = 4'($urandom); while (op == 4'hA || op == 4'hC || op == 4'hE || op == 4'hF);
         rom1[i] = {op, 4'($urandom)};
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin rom1[i] = 8'h00; rom0[i] = 8'hB5; end

      // ADD carry then JNC not taken; also first-instruction latency
      rom1[0] = 8'h3E; rom1[1] = 8'h03; rom1[2] = 8'hE0;
      do_reset();
      tick = 1'b1;
      cycle(); check("lat_first", retires, 0);
      cycle(); check("lat_second", retires, 1);
      wait_retires("add_retire2", 2, 10);
      check("add_c", 32'(o_c), 1); check("add_z", 32'(o_z), 0);
      wait_retires("jnc_retire", 3, 10);
      check("jnc_pc", 32'(o_pc), 3);
      tick = 1'b0;

      // SUB borrow, SUB to zero, JZ taken
      rom1[0] = 8'h32; rom1[1] = 8'h83; rom1[2] = 8'h8F; rom1[3] = 8'hA7;
      do_reset();
      tick = 1'b1;
      wait_retires("sub_retire2", 2, 10);
      check("sub_borrow_c", 32'(o_c), 1); check("sub_borrow_z", 32'(o_z), 0);
      wait_retires("sub_retire3", 3, 10);
      check("sub_zero_c", 32'(o_c), 0); check("sub_zero_z", 32'(o_z), 1);
      wait_retires("jz_retire", 4, 10);
      check("jz_pc", 32'(o_pc), 7);
      tick = 1'b0;

      // Single-step: first edge lands in WAIT (pending path), one held long, ticks ignored
      fill_safe(16);
      do_reset();
      step_mode = 1'b1;
      for (int i = 0; i < 80; i++) begin
         step = (i < 2) || (i >= 8 && i < 58) || (i == 62);
         tick = 1'($urandom);
         cycle();
      end
      step = 1'b0; tick = 1'b0;
      check("step_retires", retires, 3);
      check("step_pc", 32'(o_pc), 3);

      // HALT at address 5, then async reset
      fill_safe(16);
      rom1[5] = 8'hC0;
      do_reset();
      tick = 1'b1;
      wait_retires("halt_reach", 6, 30);
      for (int i = 0; i < 10; i++) cycle();
      check("halt_retires", retires, 6);
      check("halt_flag", 32'(o_halt), 1);
      check("halt_pc", 32'(o_pc), 5);
      #1 reset_n = 1'b0;
      #1 sample();
      check("halt_rst_pc", 32'(o_pc), 0);
      check("halt_rst_halted", 32'(o_halt), 0);

      // Async reset while in WAIT with tick high
      fill_safe(16);
      do_reset();
      tick = 1'b1;
      wait_retires("wait_first", 1, 10);
      #1 reset_n = 1'b0;
      #1 sample();
      check("wrst_pc", 32'(o_pc), 0);   check("wrst_out", 32'(o_out), 0);
      check("wrst_c", 32'(o_c), 0);     check("wrst_z", 32'(o_z), 0);
      check("wrst_retire", 32'(o_ret), 0); check("wrst_halted", 32'(o_halt), 0);
      @(negedge clk); sample();
      check("wrst_no_retire", 32'(o_ret), 0);

      // ROM_LAT=0: OUT imm everywhere, PC wraps, retire every cycle
      use0 = 1'b1;
      do_reset();
      tick = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("wrap_retire", 32'(o_ret), 1);
         if (i == 15) check("wrap_pc", 32'(o_pc), 0);
      end
      check("wrap_out", 32'(o_out), 5);
      tick = 1'b0;

      // Random programs and control on both latencies
      for (int it = 0; it < 6; it++) begin
         use0 = it[0];
         for (int i = 0; i < 16; i++) begin rom1[i] = 8'($urandom); rom0[i] = 8'($urandom); end
         do_reset();
         for (int i = 0; i < 200; i++) begin
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
            step = 1'($urandom);
            cycle();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
